// File: rtl/seq_tx_if.sv
// Handshake and serial-line bundle for seq_tx: payload offer/accept, abort,
// and the serial line with its status strobes.
interface seq_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_abort;
    logic       o;
    logic       busy;
    logic       frame_done;

    modport master (
        output tx_data, tx_valid, tx_abort,
        input  tx_ready, o, busy, frame_done
    );

    modport slave (
        input  tx_data, tx_valid, tx_abort,
        output tx_ready, o, busy, frame_done
    );
endinterface

// File: rtl/seq_tx.sv
// Serial frame transmitter: preamble 1,1,0,1 then the payload byte MSB first.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after D0.
module seq_tx (
    input  logic     clk,
    input  logic     rst,
    seq_tx_if.slave  bus
);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
`endif

    // Bit n of this constant is preamble bit n as it appears on the line.
    localparam logic [3:0] PRE_BITS = 4'b1011;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n;
    logic       o_q, o_n;
    logic       last;
    logic       accept;

`ifdef SEQ_TX_PARITY_EN
    logic par_q, par_n;
    assign last = (state == PAR);
`else
    assign last = (state == DATA) && (cnt == 3'd7);
`endif

    // Ready also opens in the last-bit cycle so frames can run back to back.
    assign bus.tx_ready   = (state == IDLE) || last;
    assign accept         = bus.tx_valid && bus.tx_ready && !bus.tx_abort;
    assign bus.o          = o_q;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            o_q   <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
            o_q   <= o_n;
`ifdef SEQ_TX_PARITY_EN
            par_q <= par_n;
`endif
        end
    end

    // cnt indexes the bit currently on the line within PRE or DATA.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        o_n     = o_q;
`ifdef SEQ_TX_PARITY_EN
        par_n   = par_q;
`endif
        if (bus.tx_abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            o_n     = 1'b0;
        end else if (accept) begin
            state_n = PRE;
            cnt_n   = '0;
            shreg_n = bus.tx_data;
            o_n     = PRE_BITS[0];
`ifdef SEQ_TX_PARITY_EN
            par_n   = ^bus.tx_data;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_n = 1'b0;
                end
                PRE: begin
                    if (cnt == 3'd3) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        o_n     = shreg[7];
                        shreg_n = {shreg[6:0], 1'b0};
                    end else begin
                        cnt_n = cnt + 3'd1;
                        o_n   = PRE_BITS[cnt[1:0] + 2'd1];
                    end
                end
                DATA: begin
                    if (cnt == 3'd7) begin
                        cnt_n = '0;
`ifdef SEQ_TX_PARITY_EN
                        state_n = PAR;
                        o_n     = par_q;
`else
                        state_n = IDLE;
                        o_n     = 1'b0;
`endif
                    end else begin
                        cnt_n   = cnt + 3'd1;
                        o_n     = shreg[7];
                        shreg_n = {shreg[6:0], 1'b0};
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                PAR: begin
                    state_n = IDLE;
                    o_n     = 1'b0;
                end
`endif
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    o_n     = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: a frame-position model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_seq_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    seq_tx_if bus();
    seq_tx dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

`ifdef SEQ_TX_PARITY_EN
    localparam int FLEN = 13;
`else
    localparam int FLEN = 12;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the whole frame as a bit list and the index of the bit on the line.
    int pos = -1;
    bit frm [0:12];

    function automatic bit m_ready();
        return (pos < 0) || (pos == FLEN - 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos = -1;
        end else if (bus.tx_abort) begin
            pos = -1;
        end else if (bus.tx_valid && m_ready()) begin
            bit p;
            p = 1'b0;
            frm[0] = 1'b1; frm[1] = 1'b1; frm[2] = 1'b0; frm[3] = 1'b1;
            for (int k = 0; k < 8; k++) begin
                frm[4 + k] = bus.tx_data[7 - k];
                p = p ^ bus.tx_data[k];
            end
            frm[12] = p;
            pos = 0;
        end else if (pos >= 0) begin
            pos++;
            if (pos == FLEN) pos = -1;
        end
    end

    always @(negedge clk) begin
        check("o",          bus.o,          (pos >= 0) ? frm[pos] : 1'b0);
        check("busy",       bus.busy,       pos >= 0);
        check("frame_done", bus.frame_done, pos == FLEN - 1);
        check("tx_ready",   bus.tx_ready,   m_ready());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
    endtask

    logic [23:0] cap;
    int          nrdy, ndone;

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.tx_abort = 1'b0;
        #3;
        check("rst_o",     bus.o, 1'b0);
        check("rst_busy",  bus.busy, 1'b0);
        check("rst_done",  bus.frame_done, 1'b0);
        check("rst_ready", bus.tx_ready, 1'b1);
        step(); step();
        rst = 1'b0;
        step();

        // 0xA5 single frame; data changed mid-frame must not matter
        send1(8'hA5);
        cap = '0; ndone = 0;
        for (int i = 0; i < FLEN; i++) begin
            cap[23 - i] = bus.o;
            if (bus.frame_done) ndone++;
            if (i == 4) bus.tx_data = 8'h5A;
            if (i == 11) check("a5_done_c12", bus.frame_done, (FLEN == 12));
            step();
        end
        check("a5_bits", cap[23:12], 12'b1101_1010_0101);
`ifdef SEQ_TX_PARITY_EN
        check("a5_parity", cap[11], 1'b0);
`endif
        check("a5_ndone", ndone, 1);
        check("a5_idle_o", bus.o, 1'b0);
        check("a5_idle_busy", bus.busy, 1'b0);

        // back-to-back 0x3C then 0xC3 with tx_valid held high
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_data = 8'hC3;
        cap = '0; nrdy = 0; ndone = 0;
        for (int i = 0; i < 2 * FLEN; i++) begin
            if (i < 24) cap[23 - i] = bus.o;
            if (i < 2 * FLEN - 1 && bus.tx_ready) nrdy++;
            if (bus.frame_done) ndone++;
            if (i == FLEN - 1) check("b2b_ready_last", bus.tx_ready, 1'b1);
            step();
            if (i == FLEN) bus.tx_valid = 1'b0;
        end
`ifndef SEQ_TX_PARITY_EN
        check("b2b_bits", cap, 24'b1101_0011_1100_1101_1100_0011);
`endif
        check("b2b_nready", nrdy, 1);
        check("b2b_ndone", ndone, 2);
        check("b2b_idle_o", bus.o, 1'b0);
        step();

        // abort while D3 is on the line
        send1(8'h5A);
        for (int i = 0; i < 8; i++) step();
        check("abort_at_d3", bus.o, 1'b1);
        bus.tx_abort = 1'b1;
        step();
        bus.tx_abort = 1'b0;
        check("abort_o", bus.o, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_ready", bus.tx_ready, 1'b1);
        check("abort_done", bus.frame_done, 1'b0);
        send1(8'h81);
        for (int i = 0; i < FLEN + 1; i++) step();

        // abort beats accept on the same edge
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        bus.tx_abort = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        bus.tx_abort = 1'b0;
        check("abort_wins_busy", bus.busy, 1'b0);
        step();

        // asynchronous reset in the preamble, then accept on the first edge
        send1(8'h96);
        step();
        #1 rst = 1'b1;
        #1;
        check("arst_o", bus.o, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_ready", bus.tx_ready, 1'b1);
        #1 rst = 1'b0;
        bus.tx_data  = 8'h07;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        check("arst_accept", bus.busy, 1'b1);
        for (int i = 0; i < FLEN + 1; i++) step();

        // edge payloads
        send1(8'h00);
        for (int i = 0; i < FLEN + 1; i++) step();
        send1(8'hFF);
        for (int i = 0; i < FLEN + 1; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high; forces reset state while high.
REQ-003 tx_data  input  8  payload byte; sampled only on an accept edge.
REQ-004 tx_valid  input  1  payload offered; may stay high across frames.
REQ-005 tx_ready  output  1  block can accept a payload this cycle (combinational from state).
REQ-006 tx_abort  input  1  synchronous frame abort.
REQ-007 o  output  1  registered serial line; idle level 0.
REQ-008 busy  output  1  high while any frame bit is being driven on o.
REQ-009 frame_done  output  1  one-cycle pulse coincident with the last frame bit on o.

Function
REQ-010 The block SHALL serialize frames of preamble 1,1,0,1 followed by tx_data[7:0] MSB first, the bit stream the team's "1101" Mealy detector locks onto.
REQ-011 States SHALL be IDLE, PRE (4 bits), DATA (8 bits), and PAR (1 bit, only when compiled in); a bit counter indexes bits within PRE and DATA.
REQ-012 Accept SHALL occur on a rising edge where tx_valid && tx_ready && !tx_abort; tx_data is latched into a shift register on that edge.
REQ-013 tx_ready SHALL be high in IDLE and during the cycle o carries the last frame bit; low otherwise.
REQ-014 On the accept edge o SHALL load preamble bit 0 (1); each following edge advances exactly one bit, so frame bit n is on o in cycle n after accept.
REQ-015 Frame length SHALL be 12 cycles (13 with parity); busy and o valid for exactly those cycles.
REQ-016 If accept occurs during the last-bit cycle, the next edge SHALL load preamble bit 0 with zero idle gap (back-to-back frames).
REQ-017 If no accept occurs at the last-bit edge, the FSM SHALL go to IDLE and o SHALL return to 0.
REQ-018 tx_valid deasserting mid-frame SHALL have no effect; tx_data changes after accept SHALL not affect the frame in flight.
REQ-019 tx_abort high at an edge SHALL force IDLE, o=0, busy=0, no frame_done, counter cleared; abort takes priority over accept on the same edge.
REQ-020 frame_done SHALL not pulse for aborted frames.

Reset
REQ-021 While rst is high: state IDLE, counter 0, shift register 0, o=0, busy=0, frame_done=0, tx_ready=1.
REQ-022 rst asserted mid-frame SHALL discard the frame immediately (asynchronously); first accept is possible on the first rising edge after rst falls.

Configuration
REQ-023 Macro SEQ_TX_PARITY_EN SHALL control a trailing parity bit.
REQ-024 Defined: PAR state appends even parity (XOR of the 8 data bits) after bit D0; frame is 13 bits; frame_done and the tx_ready window move to the parity bit.
REQ-025 Undefined: no PAR state, no parity logic; frame is 12 bits, last bit is D0.

Verification
REQ-026 Reset then tx_data=0xA5, tx_valid 1 cycle -> o = 1,1,0,1,1,0,1,0,0,1,0,1 on cycles 1-12, frame_done on cycle 12, o=0 cycle 13.
REQ-027 Same with SEQ_TX_PARITY_EN -> bit 13 = 0 (0xA5 has four ones), frame_done on cycle 13; 0x07 -> parity bit 1.
REQ-028 tx_valid held high with 0x3C then 0xC3 -> two frames 24 contiguous bits, no gap, two frame_done pulses, tx_ready high only in cycles 0 and 12.
REQ-029 tx_abort at data bit 3 -> o=0 and busy=0 next cycle, tx_ready=1, no frame_done; a new accept then yields a full clean frame.
REQ-030 rst pulsed asynchronously between clock edges mid-preamble -> o=0 and busy=0 before the next edge; tx_data changed mid-frame -> transmitted bits unchanged.
